sr_latch_driver: RTL

- Controller on the write side of a bank of clocked SR storage latches (q reset-low, s/r hold/set/clear, s=r=1 illegal).
- Accepts a target bit vector over a valid/ready handshake and produces non-overlapping set/reset pulses for each latch.
- After each pulse it reads back the latch outputs and retries on mismatch. Reports done or err.
- Guarantees the illegal s=r=1 combination is never driven on any bit.

---
 rtl/sr_latch_if.sv | 14 +
 rtl/sr_latch_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sr_latch_if.sv
// Command handshake between a requester and the SR latch write driver.
//   in_valid : requester has a target vector on in_data
//   in_ready : driver can take a command this cycle
//   in_data  : target latch values, one bit per latch
interface sr_latch_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sr_latch_driver.sv
// Write-side controller for a bank of clocked SR latches. It takes a target
// vector, pulses set/reset only on the bits that must change, lets the latches
// settle, reads q_fb back and retries up to MAX_RETRY extra times.
// s and r are never both high on any bit.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : command handshake (in_valid / in_ready / in_data)
//   q_fb       : latch q readback
//   s, r       : registered set / reset strobes
//   busy       : not idle
//   done, err  : one-cycle result pulses (match / retries exhausted)
//   attempts   : attempts used by the last or current command
module sr_latch_driver #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned MAX_RETRY  = 2,
    localparam int unsigned ATT_W     = $clog2(MAX_RETRY + 2)
) (
    input  logic             clk,
    input  logic             rst,
    sr_latch_if.slave        bus,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ATT_W-1:0] attempts
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PULSE  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] VERIFY = 2'd3;

    // One down-counter serves both the pulse and the settle phase.
    localparam int unsigned CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] target, target_nx;
    logic [WIDTH-1:0] s_nx, r_nx;
    logic             done_nx, err_nx;
    logic [ATT_W-1:0] attempts_nx;
    logic             launch;
    logic [WIDTH-1:0] mask_src, set_mask, clr_mask;

    // Masks come from the incoming command while idle, else from the held target.
    assign mask_src = (state == IDLE) ? bus.in_data : target;
    assign set_mask = mask_src & ~q_fb;
    assign clr_mask = ~mask_src & q_fb;

    assign bus.in_ready = (state == IDLE) && !rst;
    assign busy         = (state != IDLE);

    // Next-state and registered-output logic.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        target_nx   = target;
        s_nx        = s;
        r_nx        = r;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        attempts_nx = attempts;
        launch      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    target_nx   = bus.in_data;
                    attempts_nx = ATT_W'(1);
                    launch      = 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    s_nx     = '0;
                    r_nx     = '0;
                    cnt_nx   = CNT_W'(SETTLE_CYC - 1);
                    state_nx = SETTLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nx = VERIFY;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            VERIFY: begin
                if (q_fb == target) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (attempts <= ATT_W'(MAX_RETRY)) begin
                    attempts_nx = attempts + ATT_W'(1);
                    launch      = 1'b1;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Start an attempt: pulse only the bits that differ, or go straight
        // to readback when nothing needs to change. set/clr masks are
        // disjoint by construction, so s&r stays zero.
        if (launch) begin
            if ((set_mask | clr_mask) == '0) begin
                s_nx     = '0;
                r_nx     = '0;
                state_nx = VERIFY;
            end else begin
                s_nx     = set_mask;
                r_nx     = clr_mask;
                cnt_nx   = CNT_W'(PULSE_CYC - 1);
                state_nx = PULSE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            target   <= '0;
            s        <= '0;
            r        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            attempts <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            target   <= target_nx;
            s        <= s_nx;
            r        <= r_nx;
            done     <= done_nx;
            err      <= err_nx;
            attempts <= attempts_nx;
        end
    end

endmodule
